// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter serialising icache/dcache line refills and writebacks
// onto a single burst memory port; each line moves as BEATS consecutive beats.
module cache_mem_arbiter #(
  parameter int LINE_BITS   = 256,
  parameter int BEAT_BITS   = 64,
  parameter int OFFSET_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_read,
  input  logic [31:0]          i_address,
  output logic [LINE_BITS-1:0] i_rdata,
  output logic                 i_resp,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [31:0]          d_address,
  input  logic [LINE_BITS-1:0] d_wdata,
  output logic [LINE_BITS-1:0] d_rdata,
  output logic                 d_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [31:0]          pmem_address,
  output logic [BEAT_BITS-1:0] pmem_wdata,
  input  logic [BEAT_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp
);
  localparam int BEATS = LINE_BITS / BEAT_BITS;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] I_RD = 3'd1;
  localparam logic [2:0] D_RD = 3'd2;
  localparam logic [2:0] D_WR = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     beat_q, beat_d;
  logic [LINE_BITS-1:0] line_q, line_d;
  logic [LINE_BITS-1:0] wdata_q, wdata_d;
  logic [31:0]          addr_q, addr_d;
  logic                 last_d_q, last_d_d;     // last grant went to dcache
  logic                 served_d_q, served_d_d; // current burst belongs to dcache

  logic i_req, d_req, grant_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;
  // On contention the cache opposite the previous grant wins.
  assign grant_d = d_req & (~i_req | ~last_d_q);

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    line_d     = line_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    last_d_d   = last_d_q;
    served_d_d = served_d_q;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        if (i_req || d_req) begin
          served_d_d = grant_d;
          last_d_d   = grant_d;
          if (grant_d) begin
            addr_d = d_address;
            if (d_write) begin
              state_d = D_WR;
              wdata_d = d_wdata;
            end else begin
              state_d = D_RD;
            end
          end else begin
            addr_d  = i_address;
            state_d = I_RD;
          end
        end
      end
      I_RD, D_RD, D_WR: begin
        if (pmem_resp) begin
          if (state_q != D_WR)
            line_d[beat_q*BEAT_BITS +: BEAT_BITS] = pmem_rdata;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = RESP;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      line_q     <= '0;
      wdata_q    <= '0;
      addr_q     <= '0;
      last_d_q   <= 1'b0;
      served_d_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      line_q     <= line_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      last_d_q   <= last_d_d;
      served_d_q <= served_d_d;
    end
  end

  assign pmem_read    = (state_q == I_RD) || (state_q == D_RD);
  assign pmem_write   = (state_q == D_WR);
  assign pmem_address = {addr_q[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign pmem_wdata   = pmem_write ? wdata_q[beat_q*BEAT_BITS +: BEAT_BITS] : '0;
  assign i_rdata      = line_q;
  assign d_rdata      = line_q;
  assign i_resp       = (state_q == RESP) && !served_d_q;
  assign d_resp       = (state_q == RESP) && served_d_q;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: reset, read/write bursts, stalls,
// round-robin contention and the read+write dcache corner.
module tb_cache_mem_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic         i_read, d_read, d_write, pmem_resp;
  logic [31:0]  i_address, d_address, pmem_address;
  logic [255:0] i_rdata, d_rdata, d_wdata;
  logic         i_resp, d_resp, pmem_read, pmem_write;
  logic [63:0]  pmem_wdata, pmem_rdata;

  int errors = 0;
  int checks = 0;

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed four beats with pmem_resp every cycle, starting in burst cycle 1.
  task automatic feed4(input logic [63:0] base);
    for (int b = 0; b < 4; b++) begin
      pmem_resp  = 1'b1;
      pmem_rdata = base + 64'(b);
      tick();
    end
    pmem_resp = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
    #3;
    checks++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0 || pmem_address !== 32'h0 ||
        pmem_wdata !== 64'h0 || i_rdata !== 256'h0 || d_rdata !== 256'h0) begin
      errors++;
      $display("FAIL reset_outputs: rd=%b wr=%b iresp=%b dresp=%b addr=%h expected all 0",
               pmem_read, pmem_write, i_resp, d_resp, pmem_address);
    end
    tick(); rst = 1'b1; tick();
  endtask

  task automatic test_reset_mid_burst();
    i_read = 1; i_address = 32'h0000_5678;
    tick();               // burst cycle 1
    pmem_resp = 1; pmem_rdata = 64'hAAAA;
    tick(); tick();       // counter now 2
    checks++;
    if (pmem_read !== 1'b1) begin
      errors++; $display("FAIL mid_burst_active: pmem_read=%b expected 1", pmem_read);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (pmem_read !== 1'b0 || i_resp !== 1'b0 || i_rdata !== 256'h0) begin
      errors++;
      $display("FAIL async_reset: pmem_read=%b i_resp=%b i_rdata=%h expected 0 0 0",
               pmem_read, i_resp, i_rdata);
    end
    i_read = 0; pmem_resp = 0;
    tick(); rst = 1'b1; tick(); tick();
    checks++;
    if (pmem_read !== 1'b0 || i_resp !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: pmem_read=%b i_resp=%b expected 0 0", pmem_read, i_resp);
    end
  endtask

  task automatic test_icache_read();
    logic [63:0] w [4];
    logic        early;
    w[0] = 64'h1111_1111_1111_1111; w[1] = 64'h2222_2222_2222_2222;
    w[2] = 64'h3333_3333_3333_3333; w[3] = 64'h4444_4444_4444_4444;
    i_read = 1; i_address = 32'h0000_1234;
    pmem_resp = 1; pmem_rdata = 64'hDEAD;   // idle-cycle pmem_resp must be ignored
    tick();
    checks++;
    if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 32'h0000_1220) begin
      errors++;
      $display("FAIL icache_start: rd=%b wr=%b addr=%h expected 1 0 00001220",
               pmem_read, pmem_write, pmem_address);
    end
    early = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (i_resp !== 1'b0) early = 1'b1;
      pmem_resp = 1; pmem_rdata = w[b];
      tick();
    end
    pmem_resp = 0;
    checks++;
    if (early) begin errors++; $display("FAIL icache_early_resp: i_resp seen before cycle 5 expected 0"); end
    checks++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0 || pmem_read !== 1'b0) begin
      errors++;
      $display("FAIL icache_resp: i_resp=%b d_resp=%b rd=%b expected 1 0 0", i_resp, d_resp, pmem_read);
    end
    checks++;
    if (i_rdata !== {w[3], w[2], w[1], w[0]}) begin
      errors++; $display("FAIL icache_rdata: got %h expected %h", i_rdata, {w[3], w[2], w[1], w[0]});
    end
    tick(); i_read = 0;
    checks++;
    if (i_resp !== 1'b0) begin errors++; $display("FAIL icache_resp_pulse: i_resp=%b expected 0", i_resp); end
    tick();
  endtask

  task automatic test_dcache_write(input logic rd_too);
    logic [63:0] w [4];
    logic        bad_rd;
    w[0] = 64'hA0A0_0000_0000_000A; w[1] = 64'hB0B0_0000_0000_000B;
    w[2] = 64'hC0C0_0000_0000_000C; w[3] = 64'hD0D0_0000_0000_000D;
    if (rd_too) begin w[0] = ~w[0]; w[3] = ~w[3]; end
    d_write = 1; d_read = rd_too; d_address = 32'h8000_0047;
    d_wdata = {w[3], w[2], w[1], w[0]};
    tick();
    bad_rd = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (pmem_read !== 1'b0) bad_rd = 1'b1;
      checks++;
      if (pmem_write !== 1'b1 || pmem_wdata !== w[b] || pmem_address !== 32'h8000_0040) begin
        errors++;
        $display("FAIL dwrite_beat%0d: wr=%b wdata=%h addr=%h expected 1 %h 80000040",
                 b, pmem_write, pmem_wdata, pmem_address, w[b]);
      end
      pmem_resp = 1;
      tick();
    end
    pmem_resp = 0;
    if (pmem_read !== 1'b0) bad_rd = 1'b1;
    checks++;
    if (bad_rd) begin errors++; $display("FAIL dwrite_no_read: pmem_read asserted during write expected 0"); end
    checks++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0 || pmem_write !== 1'b0) begin
      errors++;
      $display("FAIL dwrite_resp: d_resp=%b i_resp=%b wr=%b expected 1 0 0", d_resp, i_resp, pmem_write);
    end
    tick(); d_write = 0; d_read = 0; tick();
  endtask

  task automatic test_stall();
    logic        pat [7];
    logic [63:0] exp [4];
    logic        unstable, early;
    int          k;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    d_read = 1; d_address = 32'h0000_0ABC;
    tick();
    unstable = 1'b0; early = 1'b0; k = 0;
    for (int c = 0; c < 7; c++) begin
      if (pmem_address !== 32'h0000_0AA0 || pmem_read !== 1'b1) unstable = 1'b1;
      if (d_resp !== 1'b0) early = 1'b1;
      pmem_resp  = pat[c];
      pmem_rdata = 64'hC000_0000_0000_0000 | 64'(c);
      if (pat[c]) begin exp[k] = pmem_rdata; k++; end
      tick();
    end
    pmem_resp = 0;
    checks++;
    if (unstable) begin errors++; $display("FAIL stall_addr_stable: address/read changed expected 00000aa0 held"); end
    checks++;
    if (early) begin errors++; $display("FAIL stall_early_resp: d_resp before final beat expected 0"); end
    checks++;
    if (d_resp !== 1'b1 || d_rdata !== {exp[3], exp[2], exp[1], exp[0]}) begin
      errors++;
      $display("FAIL stall_resp: d_resp=%b d_rdata=%h expected 1 %h", d_resp, d_rdata,
               {exp[3], exp[2], exp[1], exp[0]});
    end
    tick(); d_read = 0; tick();
  endtask

  task automatic test_contention();
    rst = 0; tick(); rst = 1;
    i_read = 1; i_address = 32'h0000_1000;
    d_read = 1; d_address = 32'h0000_2000;
    tick();
    checks++;
    if (pmem_address !== 32'h0000_2000 || pmem_read !== 1'b1) begin
      errors++; $display("FAIL contend_first: addr=%h rd=%b expected 00002000 1", pmem_address, pmem_read);
    end
    feed4(64'h100);
    checks++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
      errors++; $display("FAIL contend_d_resp: d_resp=%b i_resp=%b expected 1 0", d_resp, i_resp);
    end
    tick(); d_read = 0;   // IDLE: waiting icache request granted here
    tick();
    checks++;
    if (pmem_address !== 32'h0000_1000 || pmem_read !== 1'b1) begin
      errors++; $display("FAIL contend_second: addr=%h rd=%b expected 00001000 1", pmem_address, pmem_read);
    end
    feed4(64'h200);
    checks++;
    if (i_resp !== 1'b1 || i_rdata[63:0] !== 64'h200 || i_rdata[255:192] !== 64'h203) begin
      errors++; $display("FAIL contend_i_resp: i_resp=%b rdata=%h expected 1 ..203..200", i_resp, i_rdata);
    end
    tick();
    d_read = 1; d_address = 32'h0000_3000; i_address = 32'h0000_4000;
    tick();
    checks++;
    if (pmem_address !== 32'h0000_3000) begin
      errors++; $display("FAIL contend_repeat: addr=%h expected 00003000", pmem_address);
    end
    feed4(64'h300);
    tick(); i_read = 0; d_read = 0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_reset_mid_burst();
    test_icache_read();
    test_dcache_write(1'b0);
    test_stall();
    test_contention();
    test_dcache_write(1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
